// File: rtl/stack_arb_pkg.sv
// -----------------------------------------------------------------------------
// stack_arb_pkg
// Shared definitions for the stack arbiter and the calculator top that owns it:
//   op_e     - requester operation codes (push, pop, replace, clear)
//   state_e  - arbiter FSM state encodings
//   op_rejected() - decides whether an op must be refused for the current
//                   stack occupancy
// -----------------------------------------------------------------------------
package stack_arb_pkg;

   typedef enum logic [1:0] {
      OP_PUSH    = 2'b00,
      OP_POP     = 2'b01,
      OP_REPLACE = 2'b10,
      OP_CLEAR   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      GAP   = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Pop/replace need at least one element; push needs a free slot.
   // Clear is always legal.
   function automatic logic op_rejected(input op_e op, input logic empty,
                                        input logic full);
      logic rej;
      rej = 1'b0;
      case (op)
         OP_PUSH:            rej = full;
         OP_POP, OP_REPLACE: rej = empty;
         default:            rej = 1'b0;
      endcase
      return rej;
   endfunction

endpackage

// File: rtl/stack_arb_if.sv
// -----------------------------------------------------------------------------
// stack_arb_if
// Bundles every signal of the stack arbiter except clk/reset.
//   Requester side : rN_req, rN_op, rN_data (to arbiter), rN_gnt, rN_done
//   Shared result  : res_top, res_size, res_err (valid while a done is high)
//   Stack command  : st_push, st_pop, st_replace, st_reset, st_in
//   Stack status   : st_top, st_size, st_error, st_vld
//   Status         : busy
// Modports: slave = arbiter view, master = requesters + stack view.
// -----------------------------------------------------------------------------
interface stack_arb_if #(
   parameter int W  = 32,
   parameter int SW = 10
);
   logic          r0_req;
   logic [1:0]    r0_op;
   logic [W-1:0]  r0_data;
   logic          r0_gnt;
   logic          r0_done;

   logic          r1_req;
   logic [1:0]    r1_op;
   logic [W-1:0]  r1_data;
   logic          r1_gnt;
   logic          r1_done;

   logic [W-1:0]  res_top;
   logic [SW-1:0] res_size;
   logic          res_err;

   logic          st_push;
   logic          st_pop;
   logic          st_replace;
   logic          st_reset;
   logic [W-1:0]  st_in;

   logic [W-1:0]  st_top;
   logic [SW-1:0] st_size;
   logic          st_error;
   logic          st_vld;

   logic          busy;

   modport slave (
      input  r0_req, r0_op, r0_data, r1_req, r1_op, r1_data,
      input  st_top, st_size, st_error, st_vld,
      output r0_gnt, r0_done, r1_gnt, r1_done,
      output res_top, res_size, res_err,
      output st_push, st_pop, st_replace, st_reset, st_in,
      output busy
   );

   modport master (
      output r0_req, r0_op, r0_data, r1_req, r1_op, r1_data,
      output st_top, st_size, st_error, st_vld,
      input  r0_gnt, r0_done, r1_gnt, r1_done,
      input  res_top, res_size, res_err,
      input  st_push, st_pop, st_replace, st_reset, st_in,
      input  busy
   );

endinterface

// File: rtl/stack_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector, purely combinational.
//   req[1:0] in  - request lines of requester 1 and 0
//   last     in  - requester served most recently
//   sel      out - index of the requester to serve (meaningful when |req)
// On contention the requester that was not served last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       sel
);

   assign sel = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/stack_arb.sv
// -----------------------------------------------------------------------------
// stack_arb
// Arbitrates two requesters onto a single stack unit. One operation is in
// flight at a time: IDLE -> ISSUE (command pulse) -> GAP -> WAIT (until the
// stack reports st_vld, or TMO cycles elapse) -> DONE (result + done) -> IDLE.
// Ops the stack cannot honour (pop/replace when empty, push when full) are
// answered immediately with gnt+done and res_err, without touching the stack.
//   clk   in  - clock
//   reset in  - synchronous active-high reset
//   bus       - stack_arb_if.slave (requesters, stack command/status, busy)
// Parameters: W word width, SW size width, DEPTH capacity, TMO wait limit.
// -----------------------------------------------------------------------------
module stack_arb
   import stack_arb_pkg::*;
#(
   parameter int W     = 32,
   parameter int SW    = 10,
   parameter int DEPTH = 1023,
   parameter int TMO   = 255
) (
   input  logic        clk,
   input  logic        reset,
   stack_arb_if.slave  bus
);

   localparam int CW = (TMO > 1) ? $clog2(TMO) + 1 : 1;

   state_e        state_q, state_d;
   op_e           op_q;
   logic [W-1:0]  data_q;
   logic          sel_q;      // requester being served
   logic          rej_q;      // op refused at selection time
   logic          tmo_q;      // stack never answered
   logic          last_q;     // requester served most recently
   logic [CW-1:0] cnt_q;

   logic [1:0]    req;
   logic          sel;
   op_e           req_op;
   logic [W-1:0]  req_data;
   logic          st_empty, st_full;
   logic          accept, reject, timeout;

   logic [1:0]    gnt, done;

   assign req      = {bus.r1_req, bus.r0_req};
   assign req_op   = op_e'(sel ? bus.r1_op : bus.r0_op);
   assign req_data = sel ? bus.r1_data : bus.r0_data;
   assign st_empty = (bus.st_size == '0);
   assign st_full  = (bus.st_size == SW'(DEPTH));

   rr_arb2 u_rr (
      .req  (req),
      .last (last_q),
      .sel  (sel)
   );

   // Next-state logic.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            // Status is only trusted while the stack is idle (st_vld).
            if (bus.st_vld && (|req)) begin
               accept  = 1'b1;
               reject  = op_rejected(req_op, st_empty, st_full);
               state_d = reject ? DONE : ISSUE;
            end
         end
         ISSUE: state_d = GAP;
         GAP:   state_d = WAIT;
         WAIT: begin
            if (bus.st_vld) begin
               state_d = DONE;
            end else if (cnt_q == CW'(TMO - 1)) begin
               timeout = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: the latched op/data are reset too, even though outputs are
         // gated by state, so nothing stale survives an aborted operation.
         state_q <= IDLE;
         op_q    <= OP_PUSH;
         data_q  <= '0;
         sel_q   <= 1'b0;
         rej_q   <= 1'b0;
         tmo_q   <= 1'b0;
         last_q  <= 1'b1;   // "last served = 1" gives requester 0 priority
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= req_op;
            data_q <= req_data;
            sel_q  <= sel;
            last_q <= sel;
            rej_q  <= reject;
            tmo_q  <= 1'b0;
         end
         if (state_q == GAP) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (timeout) begin
            tmo_q <= 1'b1;
         end
      end
   end

   // Output decode, purely from state so reset clears everything at once.
   always_comb begin
      gnt            = '0;
      done           = '0;
      bus.st_push    = 1'b0;
      bus.st_pop     = 1'b0;
      bus.st_replace = 1'b0;
      bus.st_reset   = 1'b0;
      bus.st_in      = '0;
      bus.res_top    = '0;
      bus.res_size   = '0;
      bus.res_err    = 1'b0;
      case (state_q)
         ISSUE: begin
            gnt[sel_q] = 1'b1;
            bus.st_in  = data_q;
            case (op_q)
               OP_PUSH:    bus.st_push    = 1'b1;
               OP_POP:     bus.st_pop     = 1'b1;
               OP_REPLACE: bus.st_replace = 1'b1;
               default:    bus.st_reset   = 1'b1;
            endcase
         end
         DONE: begin
            // A rejected op never passed through ISSUE, so its grant is
            // given together with done.
            gnt[sel_q]   = rej_q;
            done[sel_q]  = 1'b1;
            bus.res_top  = bus.st_top;
            bus.res_size = bus.st_size;
            bus.res_err  = bus.st_error | rej_q | tmo_q;
         end
         default: ;
      endcase
   end

   assign bus.r0_gnt  = gnt[0];
   assign bus.r1_gnt  = gnt[1];
   assign bus.r0_done = done[0];
   assign bus.r1_done = done[1];
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_stack_arb.sv
// -----------------------------------------------------------------------------
// tb_stack_arb
// Directed bench for stack_arb. A small behavioural stack drives the status
// side; stimulus pushes the expected stack commands and done results into
// two queues, and a negedge monitor pops and compares them whenever the DUT
// pulses a command or a done.
// -----------------------------------------------------------------------------
module tb_stack_arb;
   import stack_arb_pkg::*;

   localparam int W     = 32;
   localparam int SW    = 10;
   localparam int DEPTH = 1023;
   localparam int TMO   = 255;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   stack_arb_if #(.W(W), .SW(SW)) bus ();

   stack_arb #(.W(W), .SW(SW), .DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic          id;
      logic [W-1:0]  top;
      logic [SW-1:0] size;
      logic          err;
      int            lat;     // cycles from gnt to done
   } done_t;

   typedef struct packed {
      logic [1:0]   op;
      logic [W-1:0] data;
   } cmd_t;

   done_t done_q[$];
   cmd_t  cmd_q[$];

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int gnt_cyc = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural stack ----------------
   logic          m_vld  = 1'b1;
   logic [SW-1:0] m_size = '0;
   logic [W-1:0]  m_top  = '0;
   int            m_cnt  = 0;
   int            m_seq  = 0;
   bit            hang   = 1'b0;   // hold st_vld low after a command
   int            vld_delay = 0;
   int            p_seq  = 0;      // preset request from the stimulus
   logic [SW-1:0] p_size = '0;
   logic [W-1:0]  p_top  = '0;

   assign bus.st_vld   = m_vld;
   assign bus.st_size  = m_size;
   assign bus.st_top   = m_top;
   assign bus.st_error = 1'b0;

   always @(negedge clk) begin
      if (p_seq != m_seq) begin
         m_seq  = p_seq;
         m_size = p_size;
         m_top  = p_top;
      end
      if (bus.st_push === 1'b1) begin
         m_size = m_size + 1'b1;
         m_top  = bus.st_in;
      end else if (bus.st_pop === 1'b1) begin
         m_size = m_size - 1'b1;
         m_top  = '0;
      end else if (bus.st_replace === 1'b1) begin
         m_top  = bus.st_in;
      end else if (bus.st_reset === 1'b1) begin
         m_size = '0;
         m_top  = '0;
      end
      if ((bus.st_push | bus.st_pop | bus.st_replace | bus.st_reset) === 1'b1) begin
         m_vld = 1'b0;
         m_cnt = vld_delay;
      end else if (!m_vld && !hang) begin
         if (m_cnt == 0) m_vld = 1'b1;
         else m_cnt--;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [3:0] cmds;
      logic [1:0] gnts, dones;
      logic [1:0] opc;
      cmd_t       c;
      done_t      d;
      cmds  = {bus.st_reset, bus.st_replace, bus.st_pop, bus.st_push};
      gnts  = {bus.r1_gnt, bus.r0_gnt};
      dones = {bus.r1_done, bus.r0_done};
      if ((|{cmds, gnts, dones}) === 1'b1)
         check("exclusive", {gnts == 2'b11, dones == 2'b11, $countones(cmds) > 1}, 0);
      if ((|gnts) === 1'b1) gnt_cyc = cyc;
      if ((|cmds) === 1'b1) begin
         opc = cmds[3] ? 2'd3 : cmds[2] ? 2'd2 : cmds[1] ? 2'd1 : 2'd0;
         check("cmd_with_gnt", |gnts, 1);
         if (cmd_q.size() == 0) begin
            check("cmd_unexpected", {opc, bus.st_in}, 0);
         end else begin
            c = cmd_q.pop_front();
            check("cmd_op", opc, c.op);
            check("cmd_in", bus.st_in, c.data);
         end
      end
      if ((|dones) === 1'b1) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", dones, 0);
         end else begin
            d = done_q.pop_front();
            check("done_id",   dones, d.id ? 2'b10 : 2'b01);
            check("res_top",   bus.res_top, d.top);
            check("res_size",  bus.res_size, d.size);
            check("res_err",   bus.res_err, d.err);
            check("done_lat",  cyc - gnt_cyc, d.lat);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic exp_cmd(input logic [1:0] op, input logic [W-1:0] data);
      cmd_t c;
      c.op = op; c.data = data;
      cmd_q.push_back(c);
   endtask

   task automatic exp_done(input logic id, input logic [W-1:0] top,
                           input logic [SW-1:0] size, input logic err,
                           input int lat);
      done_t d;
      d.id = id; d.top = top; d.size = size; d.err = err; d.lat = lat;
      done_q.push_back(d);
   endtask

   task automatic set_req(input logic id, input logic v, input logic [1:0] op,
                          input logic [W-1:0] data);
      if (id) begin
         bus.r1_req = v; bus.r1_op = op; bus.r1_data = data;
      end else begin
         bus.r0_req = v; bus.r0_op = op; bus.r0_data = data;
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) ok = 1'b1;
      end
      check("idle_reached", ok, 1);
   endtask

   task automatic wait_gnt(input logic id);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if ((id ? bus.r1_gnt : bus.r0_gnt) === 1'b1) seen = 1'b1;
      end
      set_req(id, 1'b0, 2'b00, '0);
      check("gnt_seen", seen, 1);
   endtask

   task automatic do_req(input logic id, input logic [1:0] op,
                         input logic [W-1:0] data);
      set_req(id, 1'b1, op, data);
      wait_gnt(id);
      wait_idle();
   endtask

   task automatic preset(input logic [SW-1:0] size, input logic [W-1:0] top);
      p_size = size;
      p_top  = top;
      p_seq++;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, {bus.r0_gnt, bus.r0_done, bus.r1_gnt, bus.r1_done,
                             bus.st_push, bus.st_pop, bus.st_replace,
                             bus.st_reset, bus.res_err, bus.busy}, 0);
      check({name, "_data"}, {bus.st_in, bus.res_top}, 0);
      check({name, "_size"}, bus.res_size, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      bit saw;
      set_req(1'b0, 1'b0, 2'b00, '0);
      set_req(1'b1, 1'b0, 2'b00, '0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;

      // Both requesters push continuously: r0, r1, r0, r1.
      exp_cmd(OP_PUSH, 32'h11); exp_done(1'b0, 32'h11, 10'd1, 1'b0, 3);
      exp_cmd(OP_PUSH, 32'h22); exp_done(1'b1, 32'h22, 10'd2, 1'b0, 3);
      exp_cmd(OP_PUSH, 32'h11); exp_done(1'b0, 32'h11, 10'd3, 1'b0, 3);
      exp_cmd(OP_PUSH, 32'h22); exp_done(1'b1, 32'h22, 10'd4, 1'b0, 3);
      set_req(1'b0, 1'b1, OP_PUSH, 32'h11);
      set_req(1'b1, 1'b1, OP_PUSH, 32'h22);
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if ((bus.r0_gnt | bus.r1_gnt) === 1'b1) n++;
      end
      set_req(1'b0, 1'b0, 2'b00, '0);
      set_req(1'b1, 1'b0, 2'b00, '0);
      check("rr_grants", n, 4);
      wait_idle();

      // Clear a non-empty stack.
      exp_cmd(OP_CLEAR, 32'h0); exp_done(1'b0, 32'h0, 10'd0, 1'b0, 3);
      do_req(1'b0, OP_CLEAR, 32'h0);

      // Rejections on an empty stack.
      exp_done(1'b1, 32'h0, 10'd0, 1'b1, 0);
      do_req(1'b1, OP_POP, 32'h0);
      exp_done(1'b1, 32'h0, 10'd0, 1'b1, 0);
      do_req(1'b1, OP_REPLACE, 32'hDEAD);

      // Clear on an empty stack is still issued.
      exp_cmd(OP_CLEAR, 32'h0); exp_done(1'b0, 32'h0, 10'd0, 1'b0, 3);
      do_req(1'b0, OP_CLEAR, 32'h0);

      // Minimum-latency push.
      exp_cmd(OP_PUSH, 32'hA5); exp_done(1'b0, 32'hA5, 10'd1, 1'b0, 3);
      do_req(1'b0, OP_PUSH, 32'h0000_00A5);

      // Slower stack: st_vld returns 3 cycles later.
      vld_delay = 3;
      exp_cmd(OP_REPLACE, 32'h5A); exp_done(1'b1, 32'h5A, 10'd1, 1'b0, 5);
      do_req(1'b1, OP_REPLACE, 32'h5A);
      vld_delay = 0;

      exp_cmd(OP_POP, 32'h0); exp_done(1'b0, 32'h0, 10'd0, 1'b0, 3);
      do_req(1'b0, OP_POP, 32'h0);

      // Full-stack boundary.
      preset(10'd1023, 32'h5555);
      exp_done(1'b1, 32'h5555, 10'd1023, 1'b1, 0);
      do_req(1'b1, OP_PUSH, 32'h77);
      exp_cmd(OP_POP, 32'h0); exp_done(1'b0, 32'h0, 10'd1022, 1'b0, 3);
      do_req(1'b0, OP_POP, 32'h0);
      exp_cmd(OP_PUSH, 32'h99); exp_done(1'b1, 32'h99, 10'd1023, 1'b0, 3);
      do_req(1'b1, OP_PUSH, 32'h99);

      // Timeout: st_vld stays low after ISSUE.
      preset(10'd1, 32'h33);
      hang = 1'b1;
      exp_cmd(OP_REPLACE, 32'hC3); exp_done(1'b0, 32'hC3, 10'd1, 1'b1, 257);
      do_req(1'b0, OP_REPLACE, 32'hC3);

      // While st_vld is low nothing is accepted.
      set_req(1'b1, 1'b1, OP_CLEAR, 32'h0);
      saw = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.r1_gnt === 1'b1) saw = 1'b1;
      end
      check("vld0_no_accept", saw, 0);
      repeat (40) @(negedge clk);
      exp_cmd(OP_CLEAR, 32'h0); exp_done(1'b1, 32'h0, 10'd0, 1'b0, 3);
      hang = 1'b0;
      wait_gnt(1'b1);
      wait_idle();

      // Reset during WAIT: no done, outputs cleared.
      hang = 1'b1;
      exp_cmd(OP_PUSH, 32'h44);
      set_req(1'b0, 1'b1, OP_PUSH, 32'h44);
      wait_gnt(1'b0);
      repeat (5) @(negedge clk);
      check("in_wait_busy", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("mid_reset");
      hang = 1'b0;
      repeat (3) @(negedge clk);
      exp_cmd(OP_CLEAR, 32'h0); exp_done(1'b1, 32'h0, 10'd0, 1'b0, 3);
      do_req(1'b1, OP_CLEAR, 32'h0);

      repeat (5) @(negedge clk);
      check("cmd_q_empty", cmd_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
